// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/forward control for a 5-stage MIPS pipe with a memory-wait watchdog.
module pipeline_hazard_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             pc_le,
  output logic             if_id_le,
  output logic             id_ex_le,
  output logic             id_ex_nop,
  output logic             ex_mem_le,
  output logic             mem_wb_nop,
  output logic             pc_src_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t           r_state;
  logic [7:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_stall_count;
  logic             r_mem_timeout;
  logic             w_hold;
  logic             w_lh;
  logic             w_err;
  // reset masks hazards so the pipe presents its free-running controls while held in reset
  assign w_hold = mem_access & ~mem_ready & ~reset;
  assign w_lh   = ex_load & ex_regwrite & (ex_rd != 5'd0) & ~reset &
                  ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  assign w_err  = (r_state == ERROR);
  always_comb begin
    pc_le      = ~(w_err | w_hold | w_lh);
    if_id_le   = ~(w_err | w_hold | w_lh);
    id_ex_le   = ~(w_err | w_hold);
    ex_mem_le  = ~(w_err | w_hold);
    id_ex_nop  = w_err | (w_lh & ~w_hold);
    mem_wb_nop = w_err | w_hold;
    pc_src_sel = branch_taken & ~(w_err | w_hold | w_lh);
  end
  always_comb begin
    fwd_a = (id_rs == 5'd0) ? 2'b00 :
            (ex_regwrite & (ex_rd == id_rs) & ~ex_load) ? 2'b01 :
            (mem_regwrite & (mem_rd == id_rs)) ? 2'b10 :
            (wb_regwrite & (wb_rd == id_rs)) ? 2'b11 : 2'b00;
    fwd_b = (id_rt == 5'd0) ? 2'b00 :
            (ex_regwrite & (ex_rd == id_rt) & ~ex_load) ? 2'b01 :
            (mem_regwrite & (mem_rd == id_rt)) ? 2'b10 :
            (wb_regwrite & (wb_rd == id_rt)) ? 2'b11 : 2'b00;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_wait_cnt    <= 8'd0;
      r_stall_count <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      if (~pc_le && !w_err && ~&r_stall_count) r_stall_count <= r_stall_count + 1'b1;
      if (r_state == RUN) begin
        if (w_hold) begin
          r_state    <= MEM_WAIT;
          r_wait_cnt <= 8'd1;
        end
      end else if (r_state == MEM_WAIT) begin
        if (!w_hold) begin
          r_state    <= RUN;
          r_wait_cnt <= 8'd0;
        end else if (r_wait_cnt == 8'(MAX_WAIT)) begin
          r_state       <= ERROR;
          r_mem_timeout <= 1'b1;
        end else begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
        end
      end
    end
  end
  assign mem_timeout = r_mem_timeout;
  assign stall_count = r_stall_count;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed vectors with hand-computed expectations.
module tb_pipeline_hazard_ctrl;
  logic clk = 0, reset = 1;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic id_uses_rt, ex_regwrite, ex_load, mem_regwrite, wb_regwrite, mem_access, mem_ready, branch_taken;
  logic pc_le, if_id_le, id_ex_le, id_ex_nop, ex_mem_le, mem_wb_nop, pc_src_sel, mem_timeout;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_count;
  logic [6:0] w_ctrl;
  int n_chk = 0, n_err = 0;
  localparam logic [6:0] NORM = 7'b1110100, BRN = 7'b1110101, LH = 7'b0011100,
                         HOLD = 7'b0000010, ERR = 7'b0001010;
  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_load(ex_load), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_access(mem_access), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .pc_le(pc_le), .if_id_le(if_id_le), .id_ex_le(id_ex_le), .id_ex_nop(id_ex_nop),
    .ex_mem_le(ex_mem_le), .mem_wb_nop(mem_wb_nop), .pc_src_sel(pc_src_sel),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );
  assign w_ctrl = {pc_le, if_id_le, id_ex_le, id_ex_nop, ex_mem_le, mem_wb_nop, pc_src_sel};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {id_rs, id_rt, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rt, ex_regwrite, ex_load, mem_regwrite, wb_regwrite} = '0;
    {mem_access, mem_ready, branch_taken} = '0;
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
  initial begin
    idle();
    mem_access = 1;
    #12;
    chk("rst_ctrl", w_ctrl, NORM);
    chk("rst_cnt", stall_count, 0);
    chk("rst_to", mem_timeout, 0);
    nxt(); reset = 0; idle();
    // load-use on rs
    ex_load = 1; ex_rd = 8; ex_regwrite = 1; id_rs = 8; #1;
    chk("lu_ctrl", w_ctrl, LH);
    chk("lu_fwd_a", fwd_a, 2'b00);
    nxt(); idle(); mem_rd = 8; mem_regwrite = 1; id_rs = 8; #1;
    chk("lu2_ctrl", w_ctrl, NORM);
    chk("lu2_fwd_a", fwd_a, 2'b10);
    chk("lu2_cnt", stall_count, 1);
    // rt hazard only when id_uses_rt
    nxt(); idle(); ex_load = 1; ex_regwrite = 1; ex_rd = 9; id_rt = 9; id_rs = 3; #1;
    chk("rt_nouse", w_ctrl, NORM);
    chk("rt_nouse_fb", fwd_b, 2'b00);
    id_uses_rt = 1; #1;
    chk("rt_use", w_ctrl, LH);
    nxt(); idle(); ex_load = 1; ex_regwrite = 1; #1;
    chk("rd0_nohaz", w_ctrl, NORM);
    chk("rt_cnt", stall_count, 2);
    // forwarding priority
    idle(); ex_rd = 5; mem_rd = 5; wb_rd = 5; ex_regwrite = 1; mem_regwrite = 1; wb_regwrite = 1; id_rt = 5; #1;
    chk("fwd_ex", fwd_b, 2'b01);
    ex_regwrite = 0; #1;
    chk("fwd_mem", fwd_b, 2'b10);
    mem_regwrite = 0; #1;
    chk("fwd_wb", fwd_b, 2'b11);
    id_rt = 0; #1;
    chk("fwd_r0", fwd_b, 2'b00);
    // branch gated by load hazard, taken next cycle
    nxt(); idle(); ex_load = 1; ex_regwrite = 1; ex_rd = 4; id_rs = 4; branch_taken = 1; #1;
    chk("br_lh", w_ctrl, LH);
    nxt(); idle(); branch_taken = 1; #1;
    chk("br_go", w_ctrl, BRN);
    chk("br_cnt", stall_count, 3);
    // memory wait of 3 cycles
    for (int i = 0; i < 3; i++) begin
      nxt(); idle(); mem_access = 1; branch_taken = 1; #1;
      chk($sformatf("mw_%0d", i), w_ctrl, HOLD);
    end
    nxt(); idle(); mem_access = 1; mem_ready = 1; #1;
    chk("mw_done", w_ctrl, NORM);
    chk("mw_cnt", stall_count, 6);
    nxt(); idle(); #1;
    chk("mw_run", w_ctrl, NORM);
    // watchdog: 16 hold cycles then ERROR
    for (int i = 0; i < 16; i++) begin
      nxt(); idle(); mem_access = 1; #1;
      chk($sformatf("to_h%0d", i), w_ctrl, HOLD);
      if (i == 15) chk("to_pre", mem_timeout, 0);
    end
    nxt(); idle(); mem_access = 1; mem_ready = 1; branch_taken = 1; wb_rd = 7; wb_regwrite = 1; id_rs = 7; #1;
    chk("to_flag", mem_timeout, 1);
    chk("to_ctrl", w_ctrl, ERR);
    chk("to_fwd", fwd_a, 2'b11);
    chk("to_cnt", stall_count, 22);
    nxt(); #1;
    chk("err_stay", w_ctrl, ERR);
    chk("err_cnt", stall_count, 22);
    // async reset in the middle of a memory wait
    reset = 1; #2; reset = 0;
    nxt(); idle(); mem_access = 1; #1;
    chk("ar_h0", w_ctrl, HOLD);
    nxt(); #1;
    chk("ar_h1", w_ctrl, HOLD);
    nxt(); #1;
    chk("ar_pre", stall_count, 2);
    #2; reset = 1; #1;
    chk("ar_ctrl", w_ctrl, NORM);
    chk("ar_cnt", stall_count, 0);
    chk("ar_to", mem_timeout, 0);
    nxt(); reset = 0; #1;
    chk("ar_after", w_ctrl, HOLD);
    nxt(); mem_ready = 1; #1;
    chk("ar_done", w_ctrl, NORM);
    chk("ar_cnt2", stall_count, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/forward controller for the 5-stage MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers).
- Detects load-use hazards and freezes the front end.
- Holds the whole pipe while data memory is not ready, with a timeout watchdog.
- Generates ID-stage operand forwarding selects, gates the branch PC select, and keeps a saturating stall counter.
- Branches use one architectural delay slot, so no flush is generated.

Parameters:
MAX_WAIT, 15, max consecutive mem-not-ready cycles before entering ERROR (1..255)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
id_rs  in  5  rs of instruction in ID
id_rt  in  5  rt of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_rd  in  5  WriteDestination_EX
ex_regwrite  in  1  EX instruction writes register file
ex_load  in  1  EX instruction is a load
mem_rd  in  5  WriteDestination_MEM
mem_regwrite  in  1  MEM instruction writes register file
wb_rd  in  5  WriteDestination_WB
wb_regwrite  in  1  WB instruction writes register file
mem_access  in  1  MEM instruction is a load/store
mem_ready  in  1  data memory completes access this cycle
branch_taken  in  1  branch/jump resolved taken in ID
pc_le  out  1  PC load enable
if_id_le  out  1  IF/ID load enable
id_ex_le  out  1  ID/EX load enable
id_ex_nop  out  1  ID/EX loads all-zero control (bubble)
ex_mem_le  out  1  EX/MEM load enable
mem_wb_nop  out  1  MEM/WB loads bubble
pc_src_sel  out  1  1 = PC loads branch target
fwd_a  out  2  rs operand source: 00 regfile, 01 EX, 10 MEM, 11 WB
fwd_b  out  2  rt operand source, same encoding
mem_timeout  out  1  sticky error flag
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- States: RUN, MEM_WAIT, ERROR. Reset (async, any time, including mid-stall) sets RUN, wait_cnt=0, stall_count=0, mem_timeout=0.
- All enable/select outputs are combinational from state and inputs. wait_cnt, stall_count and mem_timeout are registered.
- Output values during reset: pc_le=if_id_le=id_ex_le=ex_mem_le=1, nops=0, pc_src_sel=0 unless branch_taken, fwd per rules.
- mem_hold = mem_access & !mem_ready.
- load_haz = ex_load & ex_regwrite & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
- Priority in RUN/MEM_WAIT is mem_hold > load_haz > normal.
  - mem_hold: all four _le=0, mem_wb_nop=1, id_ex_nop=0, pc_src_sel=0.
  - load_haz (no mem_hold): pc_le=0, if_id_le=0, id_ex_le=1, id_ex_nop=1, ex_mem_le=1, pc_src_sel=0. The branch is re-evaluated next cycle.
  - Normal: all _le=1, nops=0, pc_src_sel=branch_taken.
- Transitions:
  - RUN -> MEM_WAIT when mem_hold; wait_cnt := 1.
  - MEM_WAIT stays while mem_hold and wait_cnt<MAX_WAIT; wait_cnt += 1.
  - MEM_WAIT -> RUN when mem_ready, that same cycle counting as normal/load_haz; wait_cnt := 0.
  - MEM_WAIT -> ERROR when mem_hold and wait_cnt==MAX_WAIT. mem_timeout := 1.
  - ERROR: all _le=0, both nops=1, pc_src_sel=0. Exit only via reset.
- Forwarding, computed per operand (fwd_b uses id_rt), first match wins, applies in every state:
  - src==0 -> 00.
  - EX match (ex_regwrite & ex_rd==src & !ex_load) -> 01.
  - MEM match (mem_regwrite & mem_rd==src) -> 10.
  - WB match (wb_regwrite & wb_rd==src) -> 11.
  - else 00.
  - fwd_b ignores id_uses_rt, so forwarding still applies to store data.
- stall_count increments by 1 each clock where pc_le=0 and state!=ERROR, saturating at all-ones.
- Latency: hazard response is same-cycle. A one-cycle load-use produces exactly one bubble.

Test Plan:
- Load-use: ex_load=1, ex_rd=8, ex_regwrite=1, id_rs=8 -> pc_le=0, if_id_le=0, id_ex_nop=1 for 1 cycle; next cycle (ex_load=0, mem_rd=8) fwd_a=10, pc_le=1; stall_count=1.
- Forward priority: ex_rd=mem_rd=wb_rd=5, all regwrite=1, id_rt=5, ex_load=0 -> fwd_b=01; with ex_regwrite=0 -> 10; id_rt=0 -> 00.
- Branch during load hazard: branch_taken=1 with load_haz -> pc_src_sel=0; next cycle, hazard gone -> pc_src_sel=1.
- Memory wait: mem_access=1, mem_ready=0 for 3 cycles then 1 -> all _le=0 and mem_wb_nop=1 for 3 cycles, RUN on 4th; stall_count=3.
- Timeout: MAX_WAIT=15, mem_ready held 0 -> after 16th hold cycle mem_timeout=1, state ERROR, all _le=0 until reset.
- Async reset mid-MEM_WAIT: assert reset between clock edges -> immediately RUN outputs, stall_count=0, mem_timeout=0.
